pll_lock_supervisor: RTL and testbench

Controller that sequences an ECP5 EHXPLLL: drives the PLL reset, waits for lock, qualifies lock stability, then releases a system-ready flag for downstream reset generators. Detects lock loss or lock timeout and re-runs the sequence, with a bounded retry count before a sticky fault. Runs in the always-present reference clock domain (25 MHz board clock), never on PLL outputs.

---
 rtl/pll_lock_supervisor.sv | 146 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// Reference-clock sequencer for an ECP5 EHXPLLL: pulses the PLL reset, waits for
// and qualifies lock, publishes ready, and retries a bounded number of times before faulting.
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 262144,
    parameter int unsigned STABLE_CYCLES       = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked_in,
    input  logic       relock_req,
    output logic       pll_rst_out,
    output logic       ready_out,
    output logic       fault_out,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CNT) + 1;

    localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LAST   = 4'(MAX_RETRIES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUNNING,
        FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          sync_q, lock_s_q;
    logic          pll_rst_q, pll_rst_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;
    logic          timer_clr;
    logic          fail;

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        timer_clr = 1'b0;
        fail      = 1'b0;

        if (state_q == FAULT) begin
            if (relock_req) begin
                state_d = RST_PLL;
                retry_d = '0;
            end
        end else if (relock_req) begin
            // Forces a timer restart even when already in RST_PLL
            state_d   = RST_PLL;
            timer_clr = 1'b1;
        end else begin
            case (state_q)
                RST_PLL: begin
                    if (timer_q == RST_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s_q)                   state_d = STABILIZE;
                    else if (timer_q == TIMEOUT_LAST) fail  = 1'b1;
                end
                STABILIZE: begin
                    if (!lock_s_q) begin
                        fail = 1'b1;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = RUNNING;
                        retry_d = '0;
                    end
                end
                RUNNING: begin
                    if (!lock_s_q) begin
                        state_d = RST_PLL;
                        if (loss_q != '1) loss_d = loss_q + 8'd1;
                    end
                end
                default: state_d = RST_PLL;
            endcase

            if (fail) begin
                if (retry_q == RETRY_LAST) begin
                    state_d = FAULT;
                    retry_d = RETRY_MAX;
                end else begin
                    state_d = RST_PLL;
                    retry_d = retry_q + 4'd1;
                end
            end
        end

        if (timer_clr || (state_d != state_q)) begin
            timer_d = '0;
        end else if ((state_q == RST_PLL) || (state_q == WAIT_LOCK) || (state_q == STABILIZE)) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        pll_rst_d = (state_d == RST_PLL) || (state_d == FAULT);
        ready_d   = (state_d == RUNNING);
        fault_d   = (state_d == FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_PLL;
            timer_q   <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            sync_q    <= 1'b0;
            lock_s_q  <= 1'b0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            sync_q    <= pll_locked_in;
            lock_s_q  <= sync_q;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst_out     = pll_rst_q;
    assign ready_out       = ready_q;
    assign fault_out       = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: expected values are queued when a step is
// driven and popped against the DUT when the measured response appears.
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked_in;
    logic       relock_req;
    logic       pll_rst_out;
    logic       ready_out;
    logic       fault_out;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    pll_lock_supervisor #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(50),
        .STABLE_CYCLES      (8),
        .MAX_RETRIES        (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked_in  (pll_locked_in),
        .relock_req     (relock_req),
        .pll_rst_out    (pll_rst_out),
        .ready_out      (ready_out),
        .fault_out      (fault_out),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d expected a queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        pop_check(obs);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_rst_out;
            1:       return ready_out;
            default: return fault_out;
        endcase
    endfunction

    // Counts samples while the selected output holds lvl; bounded by max.
    task automatic count_while(input int sel, input logic lvl, input int max, output int n);
        n = 0;
        while ((sig(sel) === lvl) && (n < max)) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit reached, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst           = 1'b1;
        pll_locked_in = 1'b0;
        relock_req    = 1'b0;
        repeat (3) tick();

        chk("reset_pll_rst", 32'(pll_rst_out), 1);
        chk("reset_ready", 32'(ready_out), 0);
        chk("reset_fault", 32'(fault_out), 0);
        chk("reset_retry", 32'(retry_count), 0);
        chk("reset_loss", 32'(lock_loss_count), 0);

        // Initial sequence: 4-cycle PLL reset, lock 10 cycles later.
        rst = 1'b0;
        push("t1_rst_width", 4);
        count_while(0, 1'b1, 100, n);
        pop_check(n);
        repeat (10) tick();
        pll_locked_in = 1'b1;
        // 2 synchronizer + 1 detect + 8 stable cycles
        push("t1_ready_latency", 11);
        count_while(1, 1'b0, 100, n);
        pop_check(n);
        chk("t1_retry", 32'(retry_count), 0);
        chk("t1_pll_rst_low", 32'(pll_rst_out), 0);

        // Lock loss for 3 cycles while running.
        pll_locked_in = 1'b0;
        push("t3_ready_drop", 3);
        count_while(1, 1'b1, 20, n);
        pop_check(n);
        pll_locked_in = 1'b1;
        chk("t3_loss_count", 32'(lock_loss_count), 1);
        chk("t3_retry", 32'(retry_count), 0);
        push("t3_pulse", 4);
        count_while(0, 1'b1, 20, n);
        pop_check(n);
        push("t3_relock_latency", 9);
        count_while(1, 1'b0, 100, n);
        pop_check(n);

        // Relock request while running.
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("t5_ready_low", 32'(ready_out), 0);
        chk("t5_loss_unchanged", 32'(lock_loss_count), 1);
        push("t5_pulse", 4);
        count_while(0, 1'b1, 20, n);
        pop_check(n);
        push("t5_ready_latency", 9);
        count_while(1, 1'b0, 100, n);
        pop_check(n);

        // Lock never returns: three timeouts then fault.
        pll_locked_in = 1'b0;
        push("t2_ready_drop", 3);
        count_while(1, 1'b1, 20, n);
        pop_check(n);
        chk("t2_loss_count", 32'(lock_loss_count), 2);
        for (int k = 0; k < 3; k++) begin
            chk("t2_retry_at_pulse", 32'(retry_count), 32'(k));
            push("t2_pulse", 4);
            count_while(0, 1'b1, 20, n);
            pop_check(n);
            push("t2_wait", 50);
            count_while(0, 1'b0, 200, n);
            pop_check(n);
        end
        chk("t2_fault", 32'(fault_out), 1);
        chk("t2_retry_max", 32'(retry_count), 3);
        repeat (10) tick();
        chk("t2_pll_rst_held", 32'(pll_rst_out), 1);
        chk("t2_fault_held", 32'(fault_out), 1);
        chk("t2_ready_low", 32'(ready_out), 0);

        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("t2_fault_cleared", 32'(fault_out), 0);
        chk("t2_retry_cleared", 32'(retry_count), 0);
        push("t2_new_pulse", 4);
        count_while(0, 1'b1, 20, n);
        pop_check(n);

        // Lock bounces once during STABILIZE.
        pll_locked_in = 1'b1;
        repeat (5) tick();
        pll_locked_in = 1'b0;
        tick();
        pll_locked_in = 1'b1;
        push("t4_fail_delay", 2);
        count_while(0, 1'b0, 20, n);
        pop_check(n);
        chk("t4_retry_attempt2", 32'(retry_count), 1);
        push("t4_pulse", 4);
        count_while(0, 1'b1, 20, n);
        pop_check(n);
        chk("t4_retry_waiting", 32'(retry_count), 1);
        push("t4_ready_latency", 9);
        count_while(1, 1'b0, 100, n);
        pop_check(n);
        chk("t4_retry_cleared", 32'(retry_count), 0);

        // Two timeouts, then asynchronous reset during STABILIZE.
        pll_locked_in = 1'b0;
        push("t6_ready_drop", 3);
        count_while(1, 1'b1, 20, n);
        pop_check(n);
        chk("t6_loss_count", 32'(lock_loss_count), 3);
        for (int k = 0; k < 2; k++) begin
            push("t6_pulse", 4);
            count_while(0, 1'b1, 20, n);
            pop_check(n);
            push("t6_wait", 50);
            count_while(0, 1'b0, 200, n);
            pop_check(n);
        end
        chk("t6_retry_two", 32'(retry_count), 2);
        pll_locked_in = 1'b1;
        push("t6_pulse3", 4);
        count_while(0, 1'b1, 20, n);
        pop_check(n);
        repeat (3) tick();
        chk("t6_in_stabilize_ready", 32'(ready_out), 0);
        chk("t6_in_stabilize_rst", 32'(pll_rst_out), 0);
        chk("t6_in_stabilize_retry", 32'(retry_count), 2);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_pll_rst", 32'(pll_rst_out), 1);
        chk("t6_async_ready", 32'(ready_out), 0);
        chk("t6_async_fault", 32'(fault_out), 0);
        chk("t6_async_retry", 32'(retry_count), 0);
        chk("t6_async_loss", 32'(lock_loss_count), 0);
        repeat (2) tick();
        rst = 1'b0;
        push("t6_restart_pulse", 4);
        count_while(0, 1'b1, 20, n);
        pop_check(n);
        push("t6_restart_ready", 9);
        count_while(1, 1'b0, 100, n);
        pop_check(n);
        chk("t6_restart_retry", 32'(retry_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
